// File: rtl/reg_bank.sv
// reg_bank: 32 x 32-bit register file with two registered read ports,
// one write port, write-to-read forwarding and a sticky malformed-index flag.
module reg_bank #(
  parameter int unsigned SP_INDEX = 29,
  parameter logic [31:0] SP_RESET = 32'd227
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_write,
  input  logic [4:0]  read_reg_a,
  input  logic [4:0]  read_reg_b,
  input  logic [31:0] write_reg,
  input  logic [31:0] write_data,
  output logic [31:0] read_data_a,
  output logic [31:0] read_data_b,
  output logic        addr_err
);

  logic [31:0] regs_q [32];
  logic [31:0] rd_a_q, rd_a_d;
  logic [31:0] rd_b_q, rd_b_d;
  logic        err_q, err_d;

  logic [4:0]  wr_idx;
  logic        wr_hi_zero;
  logic        wr_ok;

  // Write qualification and next-state read data with forwarding of the current write
  always_comb begin
    wr_idx     = write_reg[4:0];
    wr_hi_zero = (write_reg[31:5] == '0);
    wr_ok      = reg_write & wr_hi_zero & (wr_idx != '0);

    rd_a_d = '0;
    if (wr_ok && (wr_idx == read_reg_a)) begin
      rd_a_d = write_data;
    end else if (read_reg_a != '0) begin
      rd_a_d = regs_q[read_reg_a];
    end

    rd_b_d = '0;
    if (wr_ok && (wr_idx == read_reg_b)) begin
      rd_b_d = write_data;
    end else if (read_reg_b != '0) begin
      rd_b_d = regs_q[read_reg_b];
    end

    err_d = err_q | (reg_write & ~wr_hi_zero);
  end

  // Register storage: reset loads the stack pointer, otherwise qualified writes land
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs_q[i] <= (i == SP_INDEX) ? SP_RESET : '0;
      end
    end else if (wr_ok) begin
      regs_q[wr_idx] <= write_data;
    end
  end

  // Registered read ports and sticky error flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
      err_q  <= 1'b0;
    end else begin
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
      err_q  <= err_d;
    end
  end

  assign read_data_a = rd_a_q;
  assign read_data_b = rd_b_q;
  assign addr_err    = err_q;

endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank: vector table plus
// fill/readback and reset sequences.
module tb_reg_bank;

  logic        clk;
  logic        reset;
  logic        reg_write;
  logic [4:0]  read_reg_a;
  logic [4:0]  read_reg_b;
  logic [31:0] write_reg;
  logic [31:0] write_data;
  logic [31:0] read_data_a;
  logic [31:0] read_data_b;
  logic        addr_err;

  reg_bank #(.SP_INDEX(29), .SP_RESET(32'd227)) dut (
    .clk         (clk),
    .reset       (reset),
    .reg_write   (reg_write),
    .read_reg_a  (read_reg_a),
    .read_reg_b  (read_reg_b),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .read_data_a (read_data_a),
    .read_data_b (read_data_b),
    .addr_err    (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        we;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] wreg;
    logic [31:0] wdata;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        exp_err;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  int passed;
  int total;
  logic [31:0] mdl [32];

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
  endtask

  task automatic drive(input logic rst_n, input logic we, input logic [4:0] ra, input logic [4:0] rb,
                       input logic [31:0] wreg, input logic [31:0] wdata);
    @(negedge clk);
    reset      = rst_n;
    reg_write  = we;
    read_reg_a = ra;
    read_reg_b = rb;
    write_reg  = wreg;
    write_data = wdata;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {b, ~b, b ^ 8'h5A, 8'hC3};
  endfunction

  initial begin
    passed = 0;
    total  = 0;
    reset = 1'b0; reg_write = 1'b0; read_reg_a = '0; read_reg_b = '0;
    write_reg = '0; write_data = '0;

    //           rst we ra  rb  wreg          wdata          exp_a          exp_b          err
    vecs[0]  = '{1'b0, 1'b1, 5'd29, 5'd0,  32'd29,        32'h0000_0100, 32'h0,         32'h0,         1'b0};
    vecs[1]  = '{1'b1, 1'b0, 5'd29, 5'd0,  32'd0,         32'h0,         32'd227,       32'h0,         1'b0};
    vecs[2]  = '{1'b1, 1'b0, 5'd1,  5'd30, 32'd0,         32'h0,         32'h0,         32'h0,         1'b0};
    vecs[3]  = '{1'b1, 1'b1, 5'd2,  5'd1,  32'd31,        32'hDEAD_BEEF, 32'h0,         32'h0,         1'b0};
    vecs[4]  = '{1'b1, 1'b0, 5'd31, 5'd29, 32'd0,         32'h0,         32'hDEAD_BEEF, 32'd227,       1'b0};
    vecs[5]  = '{1'b1, 1'b1, 5'd5,  5'd5,  32'd5,         32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 5'd5,  5'd31, 32'd0,         32'h0,         32'h1234_5678, 32'hDEAD_BEEF, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 5'd0,  5'd0,  32'd0,         32'hFFFF_FFFF, 32'h0,         32'h0,         1'b0};
    vecs[8]  = '{1'b1, 1'b0, 5'd0,  5'd5,  32'd0,         32'h0,         32'h0,         32'h1234_5678, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 5'd7,  5'd8,  32'd7,         32'h1111_1111, 32'h1111_1111, 32'h0,         1'b0};
    vecs[10] = '{1'b1, 1'b1, 5'd7,  5'd7,  32'd7,         32'h2222_2222, 32'h2222_2222, 32'h2222_2222, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 5'd7,  5'd5,  32'd7,         32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 5'd5,  5'd7,  32'h0000_0025, 32'hAAAA_5555, 32'h1234_5678, 32'h2222_2222, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 5'd5,  5'd5,  32'h0000_0025, 32'hAAAA_5555, 32'h1234_5678, 32'h1234_5678, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 5'd5,  5'd29, 32'd0,         32'h0,         32'h1234_5678, 32'd227,       1'b1};
    vecs[15] = '{1'b1, 1'b1, 5'd9,  5'd0,  32'd9,         32'h0000_0009, 32'h0000_0009, 32'h0,         1'b1};
    vecs[16] = '{1'b1, 1'b1, 5'd29, 5'd9,  32'd29,        32'h0000_CAFE, 32'h0000_CAFE, 32'h0000_0009, 1'b1};
    vecs[17] = '{1'b1, 1'b0, 5'd29, 5'd9,  32'd0,         32'h0,         32'h0000_CAFE, 32'h0000_0009, 1'b1};
    vecs[18] = '{1'b0, 1'b1, 5'd29, 5'd9,  32'd29,        32'h0000_0100, 32'h0,         32'h0,         1'b0};
    vecs[19] = '{1'b1, 1'b0, 5'd29, 5'd7,  32'd0,         32'h0,         32'd227,       32'h0,         1'b0};
    vecs[20] = '{1'b1, 1'b0, 5'd31, 5'd5,  32'd0,         32'h0,         32'h0,         32'h0,         1'b0};
    vecs[21] = '{1'b1, 1'b0, 5'd9,  5'd0,  32'd0,         32'h0,         32'h0,         32'h0,         1'b0};

    for (int v = 0; v < NV; v++) begin
      drive(vecs[v].rst_n, vecs[v].we, vecs[v].ra, vecs[v].rb, vecs[v].wreg, vecs[v].wdata);
      chk("vec_read_data_a", v, read_data_a, vecs[v].exp_a);
      chk("vec_read_data_b", v, read_data_b, vecs[v].exp_b);
      chk("vec_addr_err",    v, {31'b0, addr_err}, {31'b0, vecs[v].exp_err});
    end

    // Fill every register, checking forwarding on A while B reads r0
    mdl[0] = '0;
    for (int i = 1; i < 32; i++) begin
      mdl[i] = pat(i);
      drive(1'b1, 1'b1, i[4:0], 5'd0, i, pat(i));
      chk("fill_fwd_a", i, read_data_a, pat(i));
      chk("fill_r0_b",  i, read_data_b, 32'h0);
    end

    // Read back all registers in crossing order on the two ports
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b0, i[4:0], 5'(31 - i), 32'd0, 32'h0);
      chk("readback_a", i, read_data_a, mdl[i]);
      chk("readback_b", i, read_data_b, mdl[31 - i]);
    end

    // Reset clears everything except the stack pointer
    drive(1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'h0);
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b0, i[4:0], 5'(31 - i), 32'd0, 32'h0);
      chk("postreset_a", i, read_data_a, (i == 29) ? 32'd227 : 32'h0);
      chk("postreset_b", i, read_data_b, ((31 - i) == 29) ? 32'd227 : 32'h0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
# reg_bank

Register file of the multicycle datapath: 32 general-purpose 32-bit registers with two registered read ports and one write port. It sits directly downstream of the write-register select multiplexer, which supplies the 32-bit write index (rt, rd, 29 or 31). It feeds the A/B operand registers of the datapath. The block adds write-to-read forwarding and a sticky error flag for malformed write indices.

## Interface
- `SP_INDEX`, default 29: register index reloaded with `SP_RESET` on reset.
- `SP_RESET`, default 32'd227: reset value of the stack pointer register.
- `clk`  input  1  clock; all state changes on the rising edge.
- `reset`  input  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `reg_write`  input  1  write enable.
- `read_reg_a`  input  5  read index for port A.
- `read_reg_b`  input  5  read index for port B.
- `write_reg`  input  32  write index from the write-register select mux. Bits [4:0] form the index; bits [31:5] must be zero.
- `write_data`  input  32  data to write.
- `read_data_a`  output  32  registered read data for port A.
- `read_data_b`  output  32  registered read data for port B.
- `addr_err`  output  1  sticky flag; set when a write is attempted with `write_reg[31:5]` ≠ 0.

## Operation
- Storage: 32 × 32-bit registers r0..r31.
- r0 is hardwired to zero:
  - Writes to r0 are discarded.
  - Reads of r0 always return 0.
- Write qualification: `wr_ok = reg_write & (write_reg[31:5] == 0) & (write_reg[4:0] != 0)`.
  - When `wr_ok` = 1: `r[write_reg[4:0]] <= write_data`.
- Malformed index: if `reg_write` = 1 and `write_reg[31:5]` ≠ 0:
  - No register changes.
  - `addr_err <= 1`.
  - `addr_err` stays 1 until reset.
- Read ports are computed every cycle and are independent of each other.
  - If `wr_ok` and `write_reg[4:0] == read_reg_x`: `read_data_x <= write_data` (forwarding).
  - Otherwise, if `read_reg_x == 0`: `read_data_x <= 0`.
  - Otherwise: `read_data_x <= r[read_reg_x]`.
- Both ports may read the same index, including the one being written; both receive the forwarded value.
- A write to r0 is not forwarded; a read of r0 returns 0.
- `write_data` is not modified. There is no width truncation or sign handling.

## Timing
- Reset (`reset` = 0 at a rising edge) has priority over everything else:
  - All registers cleared to 0, except r[`SP_INDEX`] = `SP_RESET`.
  - `read_data_a` = 0, `read_data_b` = 0, `addr_err` = 0.
  - `reg_write` is ignored during reset.
- Reset asserted mid-write: the pending write is lost and reset values win.
- The first cycle after reset deassertion operates normally.
  - A read of r29 in that cycle returns 227 at the following edge.
- Write latency: data presented at edge N is stored at edge N. A read issued in any later cycle returns it.
- Read latency: one cycle.
  - Index sampled at edge N; data valid on `read_data_x` after edge N until edge N+1.
  - There is no combinational path from inputs to outputs.
- Simultaneous write and read of the same index in the same cycle: the output after the edge shows the new data, never the stale value.
- Back-to-back writes to the same register: the last write wins. Forwarding always uses the current cycle's write.
- `addr_err` rises one cycle after the offending write cycle (registered).

## Test plan
- Reset, then read r29 on A and r0 on B:
  - `read_data_a` = 227, `read_data_b` = 0.
  - All other registers read 0.
- Write r31 = 32'hDEADBEEF (`write_reg` = 31), then read r31 next cycle:
  - `read_data_a` = 32'hDEADBEEF one cycle after the read index is applied.
- Same-cycle write r5 = 32'h12345678 with `read_reg_a` = `read_reg_b` = 5:
  - Both outputs = 32'h12345678 after that edge.
  - r5 retains the value on later reads.
- Write r0 = 32'hFFFFFFFF with `read_reg_a` = 0 in the same cycle and the next cycle:
  - `read_data_a` = 0 both times.
  - `addr_err` stays 0.
- Write with `write_reg` = 32'h00000025 (index bits 5, upper bit set), data 32'hAAAA5555:
  - r5 is unchanged.
  - `addr_err` = 1 from the next cycle and remains 1 through further valid writes.
  - A subsequent reset clears `addr_err`.
- Assert reset in the same cycle as a write r29 = 32'h100:
  - r29 reads 227 afterward.
  - Outputs are 0 in the cycle after reset.
